// File: rtl/lcd_sequencer.sv
// ============================================================================
// Module   : lcd_sequencer
// Purpose  : HD44780 power-on init sequencer and request issuer for the LCD
//            write stage; enforces controller execution delays between writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_sequencer #(
    parameter int T_POWERUP = 750000,
    parameter int T_CMD     = 2000,
    parameter int T_LONG    = 82000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_rs,
    input  logic [7:0]  req_byte,
    output logic        req_ready,
    output logic        init_done,
    output logic        lcd_en,
    output logic [31:0] lcd_instruction,
    output logic [31:0] lcd_data
);

    localparam int c_MAX_A = (T_POWERUP > T_LONG) ? T_POWERUP : T_LONG;
    localparam int c_MAX   = (c_MAX_A > T_CMD) ? c_MAX_A : T_CMD;
    localparam int CW      = $clog2(c_MAX + 1);

    localparam logic [CW-1:0] c_PU_LAST  = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] c_CMD_M1   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] c_LONG_M1  = CW'(T_LONG - 1);
    localparam logic [2:0]    c_INIT_LEN = 3'd6;

    localparam logic [2:0] S_POWERUP    = 3'd0;
    localparam logic [2:0] S_INIT_ISSUE = 3'd1;
    localparam logic [2:0] S_INIT_WAIT  = 3'd2;
    localparam logic [2:0] S_IDLE       = 3'd3;
    localparam logic [2:0] S_ISSUE      = 3'd4;
    localparam logic [2:0] S_WAIT       = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic          r_rs;
    logic [7:0]    r_byte;
    logic          r_init_done;
    logic          w_cnt_zero;
    logic          w_is_long;
    logic [CW-1:0] w_delay_m1;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = 8'h38;
            3'd3:             init_rom = 8'h0C;
            3'd4:             init_rom = 8'h01;
            3'd5:             init_rom = 8'h06;
            default:          init_rom = 8'h00;
        endcase
    endfunction

    assign w_cnt_zero = (r_cnt == '0);
    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    assign w_is_long  = !r_rs && (r_byte[7:2] == 6'd0) && (r_byte[1:0] != 2'd0);
    assign w_delay_m1 = w_is_long ? c_LONG_M1 : c_CMD_M1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_POWERUP;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_POWERUP:    if (r_cnt == c_PU_LAST) w_next = S_INIT_ISSUE;
            S_INIT_ISSUE: w_next = S_INIT_WAIT;
            S_INIT_WAIT:  if (w_cnt_zero) w_next = (r_idx == c_INIT_LEN) ? S_IDLE : S_INIT_ISSUE;
            S_IDLE:       if (req_valid) w_next = S_ISSUE;
            S_ISSUE:      w_next = S_WAIT;
            S_WAIT:       if (w_cnt_zero) w_next = S_IDLE;
            default:      w_next = S_POWERUP;
        endcase
    end

    always_comb begin
        lcd_en    = (r_state == S_INIT_ISSUE) || (r_state == S_ISSUE);
        req_ready = (r_state == S_IDLE);
    end

    // The output byte/rs registers load on the edge entering an issue state,
    // so they only ever change in the cycle lcd_en rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_rs        <= 1'b0;
            r_byte      <= 8'h00;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_POWERUP: begin
                    if (w_next == S_INIT_ISSUE) begin
                        r_rs   <= 1'b0;
                        r_byte <= init_rom(r_idx);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_INIT_ISSUE: begin
                    r_cnt <= w_delay_m1;
                    r_idx <= r_idx + 3'd1;
                end
                S_INIT_WAIT: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_next == S_INIT_ISSUE) begin
                        r_rs   <= 1'b0;
                        r_byte <= init_rom(r_idx);
                    end else begin
                        r_init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        r_rs   <= req_rs;
                        r_byte <= req_byte;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= w_delay_m1;
                end
                S_WAIT: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign init_done       = r_init_done;
    assign lcd_instruction = {31'b0, r_rs};
    assign lcd_data        = {24'b0, r_byte};

endmodule

`default_nettype wire

// File: tb/tb_lcd_sequencer.sv
// ============================================================================
// Module   : tb_lcd_sequencer
// Purpose  : Directed self-checking bench for lcd_sequencer (short timings).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lcd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_rs;
    logic [7:0]  req_byte;
    logic        req_ready;
    logic        init_done;
    logic        lcd_en;
    logic [31:0] lcd_instruction;
    logic [31:0] lcd_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int         exp_gap [6] = '{10, 5, 5, 5, 5, 21};

    lcd_sequencer #(
        .T_POWERUP (10),
        .T_CMD     (4),
        .T_LONG    (20)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_rs          (req_rs),
        .req_byte        (req_byte),
        .req_ready       (req_ready),
        .init_done       (init_done),
        .lcd_en          (lcd_en),
        .lcd_instruction (lcd_instruction),
        .lcd_data        (lcd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count negedges until lcd_en is seen high (bounded).
    task automatic wait_en(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lcd_en && n < 200);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    {31'b0, lcd_en},    32'd0);
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd0);
        chk({tag, "_done"},  {31'b0, init_done}, 32'd0);
        chk({tag, "_instr"}, lcd_instruction,    32'd0);
        chk({tag, "_data"},  lcd_data,           32'd0);
    endtask

    // Call at the negedge where rst_n was just released; returns at the
    // negedge where init_done is first seen high.
    task automatic run_init(input string tag);
        int n;
        for (int i = 0; i < 6; i++) begin
            wait_en(n);
            chk($sformatf("%s_gap%0d", tag, i), n, exp_gap[i]);
            chk($sformatf("%s_data%0d", tag, i), lcd_data, {24'b0, exp_rom[i]});
            chk($sformatf("%s_instr%0d", tag, i), lcd_instruction, 32'd0);
            chk($sformatf("%s_ready%0d", tag, i), {31'b0, req_ready}, 32'd0);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!init_done && n < 100);
        chk({tag, "_done_lat"}, n, 5);
        chk({tag, "_ready_at_done"}, {31'b0, req_ready}, 32'd1);
    endtask

    // Call at a negedge with req_ready high; returns at the next such negedge.
    task automatic single_req(input string tag, input logic rs, input logic [7:0] b, input int exp_low);
        int n;
        req_valid = 1'b1;
        req_rs    = rs;
        req_byte  = b;
        @(negedge clk);
        chk({tag, "_en"},    {31'b0, lcd_en},  32'd1);
        chk({tag, "_instr"}, lcd_instruction,  {31'b0, rs});
        chk({tag, "_data"},  lcd_data,         {24'b0, b});
        req_valid = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_ready_low"}, n, exp_low);
    endtask

    initial begin
        int n;
        int cnt_en;
        logic [7:0] stream [3];
        stream[0] = 8'h48;
        stream[1] = 8'h49;
        stream[2] = 8'h21;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_byte  = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");

        // Test 1: power-on wait and init sequence
        rst_n = 1'b1;
        run_init("init1");

        // Test 2: single character
        single_req("char41", 1'b1, 8'h41, 5);

        // Test 3: streaming with valid held high
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_byte  = stream[0];
        @(negedge clk);
        chk("stream0_en",   {31'b0, lcd_en}, 32'd1);
        chk("stream0_data", lcd_data, {24'b0, stream[0]});
        for (int i = 1; i < 3; i++) begin
            req_byte = stream[i];
            wait_en(n);
            chk($sformatf("stream%0d_gap", i), n, 6);
            chk($sformatf("stream%0d_data", i), lcd_data, {24'b0, stream[i]});
            chk($sformatf("stream%0d_instr", i), lcd_instruction, 32'd1);
        end
        req_valid = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("stream_ready_low", n, 5);

        // Test 4: delay selection
        single_req("clear01", 1'b0, 8'h01, 21);
        single_req("ddram80", 1'b0, 8'h80, 5);
        single_req("char01",  1'b1, 8'h01, 5);
        single_req("home02",  1'b0, 8'h02, 21);

        // Test 5a: reset during WAIT
        req_valid = 1'b1;
        req_rs    = 1'b0;
        req_byte  = 8'h01;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        run_init("init2");

        // Test 5b: reset during POWERUP
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_pu");
        @(negedge clk);
        rst_n = 1'b1;
        run_init("init3");

        // Test 6: request held from reset
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_byte  = 8'h55;
        @(negedge clk);
        rst_n = 1'b1;
        run_init("init4");
        @(negedge clk);
        chk("early_en",    {31'b0, lcd_en}, 32'd1);
        chk("early_instr", lcd_instruction, 32'd1);
        chk("early_data",  lcd_data, 32'h55);
        req_valid = 1'b0;
        cnt_en = 0;
        repeat (12) begin
            @(negedge clk);
            if (lcd_en) cnt_en++;
        end
        chk("early_once", cnt_en, 0);
        chk("early_ready", {31'b0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
